// File: rtl/mcdf_chnl_arbiter_if.sv
// mcdf_chnl_arbiter_if: channel request bundle plus formatter output bus
interface mcdf_chnl_arbiter_if #(parameter int DW = 8);
  logic [DW-1:0] ch0_data, ch1_data, ch2_data;
  logic ch0_valid, ch1_valid, ch2_valid;
  logic ch0_ready, ch1_ready, ch2_ready;
  logic [DW-1:0] fmt_data;
  logic fmt_valid, fmt_last, fmt_ready;
  logic [1:0] fmt_id;
  modport master (
    output ch0_data, ch1_data, ch2_data, ch0_valid, ch1_valid, ch2_valid, fmt_ready,
    input ch0_ready, ch1_ready, ch2_ready, fmt_data, fmt_valid, fmt_last, fmt_id
  );
  modport slave (
    input ch0_data, ch1_data, ch2_data, ch0_valid, ch1_valid, ch2_valid, fmt_ready,
    output ch0_ready, ch1_ready, ch2_ready, fmt_data, fmt_valid, fmt_last, fmt_id
  );
endinterface

// File: rtl/mcdf_chnl_arbiter.sv
// mcdf_chnl_arbiter: 3-channel priority/round-robin burst arbiter feeding the formatter
module mcdf_chnl_arbiter #(
  parameter int DW = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] cfg_en,
  input  logic [5:0] cfg_prio,
  input  logic [2:0] cfg_len,
  mcdf_chnl_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [1:0] id, rr, win, c;
  logic [2:0] cnt, len, best, vld, elig;
  logic [DW-1:0] data_q, sel_data;
  logic gnt, sel_valid, xfer;
  assign vld = {bus.ch2_valid, bus.ch1_valid, bus.ch0_valid};
  assign elig = vld & cfg_en;
  assign gnt = state == GRANT;
  assign sel_data = id == 2'd2 ? bus.ch2_data : id == 2'd1 ? bus.ch1_data : bus.ch0_data;
  assign sel_valid = id == 2'd2 ? bus.ch2_valid : id == 2'd1 ? bus.ch1_valid : bus.ch0_valid;
  assign bus.fmt_valid = gnt & sel_valid;
  assign bus.fmt_last = bus.fmt_valid & (cnt == len);
  assign bus.fmt_data = gnt ? sel_data : data_q;
  assign bus.fmt_id = id;
  assign bus.ch0_ready = gnt & (id == 2'd0) & bus.fmt_ready;
  assign bus.ch1_ready = gnt & (id == 2'd1) & bus.fmt_ready;
  assign bus.ch2_ready = gnt & (id == 2'd2) & bus.fmt_ready;
  assign xfer = bus.fmt_valid & bus.fmt_ready;
  // Scan in round-robin order from rr+1; strict < keeps the first channel of equal priority
  always_comb begin
    win = 2'd0;
    best = 3'd4;
    c = rr;
    for (int k = 0; k < 3; k++) begin
      c = c == 2'd2 ? 2'd0 : c + 2'd1;
      if (elig[c] && {1'b0, cfg_prio[{c, 1'b0} +: 2]} < best) begin
        best = {1'b0, cfg_prio[{c, 1'b0} +: 2]};
        win = c;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = |elig ? GRANT : IDLE;
    else state_nxt = xfer && bus.fmt_last ? IDLE : GRANT;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      id <= 2'd0;
      rr <= 2'd2;
      len <= 3'd0;
      cnt <= 3'd0;
      data_q <= '0;
    end else begin
      if (state == IDLE && |elig) begin
        id <= win;
        rr <= win;
        len <= cfg_len;
      end
      if (gnt) data_q <= sel_data;
      if (xfer) cnt <= bus.fmt_last ? 3'd0 : cnt + 3'd1;
    end
endmodule

// File: tb/tb_mcdf_chnl_arbiter.sv
// tb_mcdf_chnl_arbiter: directed scenarios plus random traffic against a burst-level reference model
module tb_mcdf_chnl_arbiter;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [2:0] cfg_en, cfg_len, v;
  logic [5:0] cfg_prio;
  logic [DW-1:0] d [3];
  logic fr;
  int errors = 0, checks = 0;
  bit busy;
  int owner, beats, blen, last_gnt, m_id, acc, lastbeat;
  logic [DW-1:0] m_data;
  int gq [$];

  mcdf_chnl_arbiter_if #(.DW(DW)) bus ();
  mcdf_chnl_arbiter #(.DW(DW)) dut (
    .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_prio(cfg_prio), .cfg_len(cfg_len), .bus(bus)
  );
  assign bus.ch0_data = d[0];
  assign bus.ch1_data = d[1];
  assign bus.ch2_data = d[2];
  assign bus.ch0_valid = v[0];
  assign bus.ch1_valid = v[1];
  assign bus.ch2_valid = v[2];
  assign bus.fmt_ready = fr;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    busy = 0; owner = 0; beats = 0; blen = 0; last_gnt = 2; m_id = 0; m_data = '0;
  endtask

  // Lowest score wins: priority dominates, then distance after the last granted channel
  function automatic int pick();
    int w, bs, s;
    w = -1; bs = 99;
    for (int ch = 0; ch < 3; ch++)
      if (v[ch] && cfg_en[ch]) begin
        s = int'(cfg_prio[2*ch +: 2]) * 3 + (ch - last_gnt + 2) % 3;
        if (s < bs) begin bs = s; w = ch; end
      end
    return w;
  endfunction

  task automatic check();
    logic ev, el;
    logic [2:0] er;
    logic [DW-1:0] ed;
    if (!rstn) mreset();
    ev = busy && v[owner];
    el = ev && beats == blen;
    er = busy && fr ? 3'(1 << owner) : 3'b000;
    ed = busy ? d[owner] : m_data;
    chk("fmt_valid", 32'(bus.fmt_valid), 32'(ev));
    chk("fmt_last", 32'(bus.fmt_last), 32'(el));
    chk("ch_ready", 32'({bus.ch2_ready, bus.ch1_ready, bus.ch0_ready}), 32'(er));
    chk("fmt_id", 32'(bus.fmt_id), 32'(m_id));
    chk("fmt_data", 32'(bus.fmt_data), 32'(ed));
    if (bus.fmt_valid && fr && bus.fmt_id == 2'd1) begin
      acc++;
      if (bus.fmt_last && lastbeat == 0) lastbeat = acc;
    end
  endtask

  task automatic mupdate();
    int w;
    if (!rstn) begin mreset(); return; end
    if (busy) begin
      m_data = d[owner];
      if (v[owner] && fr) begin
        if (beats == blen) begin busy = 0; beats = 0; end
        else beats++;
      end
    end else begin
      w = pick();
      if (w >= 0) begin
        busy = 1; owner = w; m_id = w; last_gnt = w; blen = int'(cfg_len); beats = 0;
        gq.push_back(w);
      end
    end
  endtask

  task automatic cycle(int n = 1);
    repeat (n) begin
      @(negedge clk); check();
      @(posedge clk); mupdate(); #1;
    end
  endtask

  task automatic rnd_data();
    for (int i = 0; i < 3; i++) d[i] = DW'($urandom);
  endtask

  task automatic rcycle(int n);
    repeat (n) begin rnd_data(); cycle(); end
  endtask

  task automatic drain();
    int n;
    n = 0;
    v = 3'b111; cfg_en = 3'b000; fr = 1'b1;
    while (busy && n < 20) begin rcycle(1); n++; end
    chk("drain_timeout", 32'(busy), 32'd0);
    cycle();
  endtask

  task automatic chk_seq(string tag, int exp [4]);
    chk({tag, "_count"}, 32'(gq.size() >= 4), 32'd1);
    if (gq.size() >= 4)
      for (int i = 0; i < 4; i++) chk(tag, 32'(gq[i]), 32'(exp[i]));
  endtask

  initial begin
    cfg_en = 3'b111; cfg_prio = 6'd0; cfg_len = 3'd0; v = 3'b000; fr = 1'b1;
    d = '{default: '0};
    mreset();
    cycle(2);
    rstn = 1'b1;
    // equal priority: plain rotation 0,1,2,0 with single-beat bursts
    v = 3'b111; gq.delete();
    rcycle(8);
    chk_seq("rr_seq", '{0, 1, 2, 0});
    // ch0 lowest priority, ch1/ch2 tie
    cfg_prio = {2'd1, 2'd1, 2'd2}; gq.delete();
    rcycle(8);
    chk_seq("prio_seq", '{1, 2, 1, 2});
    // 4-beat burst on ch1 with a throttled formatter and cfg_len changed mid-burst
    cfg_prio = 6'd0; cfg_len = 3'd3; v = 3'b010; acc = 0; lastbeat = 0;
    for (int i = 0; i < 30 && lastbeat == 0; i++) begin
      fr = (i % 2 == 0);
      if (i == 3) cfg_len = 3'd0;
      rcycle(1);
    end
    chk("burst_last_beat", 32'(lastbeat), 32'd4);
    drain();
    // ch2 drops valid for 5 cycles mid-burst
    cfg_en = 3'b111; cfg_len = 3'd3; v = 3'b100; fr = 1'b1; gq.delete();
    rcycle(2);
    v = 3'b011;
    rcycle(5);
    chk("hold_grants", 32'(gq.size()), 32'd1);
    chk("hold_busy", 32'(busy), 32'd1);
    v = 3'b111;
    rcycle(3);
    chk("hold_resume_done", 32'(busy), 32'd0);
    drain();
    // ch1 disabled
    cfg_en = 3'b101; cfg_len = 3'd0; v = 3'b111; gq.delete();
    rcycle(8);
    chk_seq("en_seq", '{0, 2, 0, 2});
    drain();
    // reset during the third beat of a 4-beat burst
    cfg_en = 3'b111; cfg_len = 3'd3; v = 3'b010; fr = 1'b1;
    rcycle(3);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.fmt_valid), 32'd0);
    chk("rst_last", 32'(bus.fmt_last), 32'd0);
    chk("rst_ready", 32'({bus.ch2_ready, bus.ch1_ready, bus.ch0_ready}), 32'd0);
    chk("rst_id", 32'(bus.fmt_id), 32'd0);
    chk("rst_data", 32'(bus.fmt_data), 32'd0);
    cycle();
    rstn = 1'b1; v = 3'b111; cfg_len = 3'd0; gq.delete();
    rcycle(2);
    chk("post_reset_count", 32'(gq.size() >= 1), 32'd1);
    if (gq.size() >= 1) chk("post_reset_winner", 32'(gq[0]), 32'd0);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      v = 3'($urandom);
      cfg_en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      if ($urandom_range(0, 7) == 0) cfg_prio = 6'($urandom);
      cfg_len = 3'($urandom);
      fr = $urandom_range(0, 3) != 0;
      rstn = $urandom_range(0, 79) != 0;
      rcycle(1);
    end
    rstn = 1'b1;
    cycle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mcdf_chnl_arbiter.md
MCDF_CHNL_ARBITER -- requirements
Module: mcdf_chnl_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning channel data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports ch0_data, ch1_data, ch2_data, input, DW bits each: channel payload.
REQ-005 The block SHALL have ports ch0_valid, ch1_valid, ch2_valid, input, 1 bit each: channel beat valid.
REQ-006 The block SHALL have ports ch0_ready, ch1_ready, ch2_ready, output, 1 bit each: channel beat accepted.
REQ-007 The block SHALL have port cfg_en, input, 3 bits: per-channel enable; bit N gates channel N.
REQ-008 The block SHALL have port cfg_prio, input, 6 bits: 2-bit priority per channel, bits [2N+1:2N]; 0 is highest.
REQ-009 The block SHALL have port cfg_len, input, 3 bits: burst length minus 1 (1..8 beats).
REQ-010 The block SHALL have port fmt_data, output, DW bits: granted channel payload.
REQ-011 The block SHALL have port fmt_valid, output, 1 bit: granted channel valid.
REQ-012 The block SHALL have port fmt_id, output, 2 bits: granted channel index (0..2).
REQ-013 The block SHALL have port fmt_last, output, 1 bit: current beat is the final beat of the burst.
REQ-014 The block SHALL have port fmt_ready, input, 1 bit: formatter accepts beat.

Function
REQ-015 The FSM SHALL have two states, IDLE and GRANT.
REQ-016 Requester N SHALL be eligible when chN_valid=1 and cfg_en[N]=1.
REQ-017 In IDLE with at least one eligible requester, the FSM SHALL move to GRANT on the next edge, registering the winner.
REQ-018 Grant latency SHALL be 1 cycle from eligibility in IDLE.
REQ-019 Winner selection SHALL pick the lowest cfg_prio value.
REQ-020 Priority ties SHALL be broken round-robin, starting at the channel after the last granted one (modulo 3).
REQ-021 On grant, cfg_len SHALL be sampled into a burst-length register; later cfg_len changes SHALL NOT affect the active burst.
REQ-022 In GRANT, fmt_data, fmt_valid and fmt_id SHALL combinationally reflect the granted channel.
REQ-023 In GRANT, the granted chN_ready SHALL equal fmt_ready; all other ch_ready SHALL be 0.
REQ-024 In IDLE, all ch_ready, fmt_valid and fmt_last SHALL be 0; fmt_data and fmt_id SHALL hold their last value.
REQ-025 A 3-bit beat counter SHALL increment on each fmt_valid&&fmt_ready in GRANT.
REQ-026 fmt_last SHALL be 1 when the counter equals the sampled length and fmt_valid=1.
REQ-027 On the transfer with fmt_last=1, the counter SHALL clear and the FSM SHALL return to IDLE; no back-to-back grant (1 idle cycle minimum between bursts).
REQ-028 A granted channel dropping valid mid-burst SHALL NOT release the grant; the burst waits.
REQ-029 Clearing cfg_en[N] mid-burst SHALL NOT abort channel N's burst; it SHALL only exclude N from the next arbitration.
REQ-030 The round-robin pointer SHALL update to the winner at each grant.

Reset
REQ-031 On rstn=0, asynchronously: FSM=IDLE; counter=0; rr pointer=2; burst length=0; fmt_id=0; fmt_data=0; fmt_valid=0; fmt_last=0; all ch_ready=0.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately, with no further ready or valid.
REQ-033 After rstn deasserts, the first arbitration SHALL favour channel 0 on a tie.

Verification
REQ-034 Scenario: all prio=0, all valid, cfg_len=0, fmt_ready=1 -> grants 0,1,2,0, each 1 beat with fmt_last=1, one IDLE cycle between grants.
REQ-035 Scenario: prio ch0=2, ch1=1, ch2=1, all valid -> grants alternate 1,2,1,2; ch0 never granted while 1 or 2 are valid.
REQ-036 Scenario: cfg_len=3, ch1 only, fmt_ready toggles 1/0 -> 4 accepted beats with fmt_id=1; fmt_last only on 4th; cfg_len changed to 0 mid-burst has no effect.
REQ-037 Scenario: ch2 granted, ch2_valid drops for 5 cycles mid-burst -> fmt_valid=0, grant held, no other ch_ready asserted; burst resumes.
REQ-038 Scenario: cfg_en=3'b101, all valid -> ch1_ready never 1; grants alternate 0,2.
REQ-039 Scenario: rstn pulsed low during beat 2 of a 4-beat burst -> all outputs 0 within the same cycle; next grant goes to ch0 on a tie.
